// File: rtl/exp_series_top.sv
// Iterative Maclaurin evaluator for e^x: x unsigned Q0.16 in, result unsigned Q2.16 out.
// Optional EXP_EARLY_EXIT_EN: finish as soon as a term underflows to zero.
module exp_series_top #(
    parameter int NTERMS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] xBus,
    output logic [17:0] rBus,
    output logic        done,
    output logic        busy
);
    // state | meaning
    // IDLE  | waiting for start
    // MULX  | T <= T*x
    // MULR  | T <= T/n via reciprocal ROM
    // ACC   | R <= R+T, advance n or finish
    // DONE  | result published, one-cycle done pulse
    typedef enum logic [2:0] {IDLE, MULX, MULR, ACC, DONE} expState;

    localparam logic [3:0] LAST_N = 4'(NTERMS - 1);

    expState     state;
    expState     stateNext;
    logic [15:0] xReg;
    logic [17:0] termReg;
    logic [17:0] sumReg;
    logic [3:0]  nCnt;
    logic [16:0] recipVal;
    logic [16:0] mulOperand;
    logic [34:0] product;
    logic [17:0] productQ;
    logic        lastTerm;

    always_comb begin
        recipVal = 17'd0;
        case (nCnt)
            4'd1:    recipVal = 17'd65536;
            4'd2:    recipVal = 17'd32768;
            4'd3:    recipVal = 17'd21845;
            4'd4:    recipVal = 17'd16384;
            4'd5:    recipVal = 17'd13107;
            4'd6:    recipVal = 17'd10922;
            4'd7:    recipVal = 17'd9362;
            4'd8:    recipVal = 17'd8192;
            4'd9:    recipVal = 17'd7281;
            4'd10:   recipVal = 17'd6553;
            4'd11:   recipVal = 17'd5957;
            4'd12:   recipVal = 17'd5461;
            4'd13:   recipVal = 17'd5041;
            4'd14:   recipVal = 17'd4681;
            4'd15:   recipVal = 17'd4369;
            default: recipVal = 17'd0;
        endcase
    end

    // One multiplier shared between the x step and the 1/n step.
    assign mulOperand = (state == MULR) ? recipVal : {1'b0, xReg};
    assign product    = 35'(termReg) * 35'(mulOperand);
    assign productQ   = 18'(product >> 16);

`ifdef EXP_EARLY_EXIT_EN
    // A zero term stays zero, so the remaining terms cannot change R.
    assign lastTerm = (nCnt == LAST_N) || (termReg == 18'd0);
`else
    assign lastTerm = (nCnt == LAST_N);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        done      = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    stateNext = MULX;
                end
            end
            MULX: stateNext = MULR;
            MULR: stateNext = ACC;
            ACC:  stateNext = lastTerm ? DONE : MULX;
            DONE: begin
                done      = 1'b1;
                stateNext = IDLE;
            end
            default: begin
                busy      = 1'b0;
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xReg    <= 16'd0;
            termReg <= 18'd0;
            sumReg  <= 18'd0;
            nCnt    <= 4'd0;
            rBus    <= 18'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        xReg    <= xBus;
                        termReg <= 18'h10000;
                        sumReg  <= 18'h10000;
                        nCnt    <= 4'd1;
                    end
                end
                MULX, MULR: termReg <= productQ;
                ACC: begin
                    sumReg <= sumReg + termReg;
                    if (lastTerm) begin
                        rBus <= sumReg + termReg;
                    end else begin
                        nCnt <= nCnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exp_series_top.sv
// Self-checking bench for exp_series_top: scoreboard of expected results and
// accept edges, checked against rBus and done timing.
module tb_exp_series_top;
    localparam int NTERMS = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] xBus = 16'd0;
    logic [17:0] rBus;
    logic        done;
    logic        busy;

    exp_series_top #(.NTERMS(NTERMS)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .xBus (xBus),
        .rBus (rBus),
        .done (done),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] res;
        int          iters;
        int          acceptEdge;
    } sbEntry;

    sbEntry sb[$];
    sbEntry popped;
    int     edgeCnt  = 0;
    int     checkCnt = 0;
    int     passCnt  = 0;
    int     failCnt  = 0;
    int     doneCnt  = 0;
    logic   prevDone = 1'b0;

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: e^x series with the truncation the unit defines.
    function automatic void model(input logic [15:0] x, output logic [17:0] res, output int iters);
        longint t = 65536;
        longint r = 65536;
        iters = 0;
        for (int n = 1; n < NTERMS; n++) begin
            t = (t * longint'(x)) >> 16;
            t = ((t * (65536 / n)) >> 16) & 'h3FFFF;
            r = r + t;
            iters = n;
`ifdef EXP_EARLY_EXIT_EN
            if (t == 0) break;
`endif
        end
        res = r[17:0];
    endfunction

    always @(negedge clk) begin
        if (rst && done) begin
            doneCnt++;
            check("done_width", {31'd0, prevDone}, 32'd0);
            check("done_expected", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                popped = sb.pop_front();
                check("rBus", {14'd0, rBus}, {14'd0, popped.res});
                check("latency", edgeCnt - popped.acceptEdge, 3 * popped.iters);
            end
        end
        prevDone = rst && done;
    end

    task automatic issue(input logic [15:0] x, input bit push);
        sbEntry e;
        @(negedge clk);
        xBus  = x;
        start = 1'b1;
        model(x, e.res, e.iters);
        e.acceptEdge = edgeCnt + 1;
        if (push) sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        int busyBad;
        int doneBefore;
        int a;
        int sp;
        sbEntry e;

        // Reset state
        @(negedge clk);
        check("rst_rBus", {14'd0, rBus}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // x = 0.5, plus the literal reference value
        issue(16'h8000, 1'b1);
        waitIdle(200);
        check("x_half_const", {14'd0, rBus}, 32'h1A610);

        issue(16'h0000, 1'b1);
        waitIdle(200);
        check("x_zero_const", {14'd0, rBus}, 32'h10000);

        issue(16'h0001, 1'b1);
        waitIdle(200);
        check("x_one_lsb_const", {14'd0, rBus}, 32'h10001);

        // Second start at edge 5 with a different x must be ignored
        doneBefore = doneCnt;
        busyBad = 0;
        issue(16'h8000, 1'b1);
        if (!busy) busyBad++;
        repeat (4) begin
            @(negedge clk);
            if (!busy) busyBad++;
        end
        start = 1'b1;
        xBus  = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        if (!busy) busyBad++;
        for (int k = 0; k < 100 && sb.size() != 0; k++) begin
            @(negedge clk);
            if (sb.size() != 0 && !busy) busyBad++;
        end
        check("busy_gaps", busyBad, 0);
        repeat (30) @(negedge clk);
        check("single_done", doneCnt - doneBefore, 1);
        check("ignored_start_rBus", {14'd0, rBus}, 32'h1A610);

        // start held high: back-to-back operations
        @(negedge clk);
        xBus  = 16'h8000;
        start = 1'b1;
        model(16'h8000, e.res, e.iters);
        a  = edgeCnt + 1;
        sp = 3 * e.iters + 2;
        for (int k = 0; k < 3; k++) begin
            e.acceptEdge = a + k * sp;
            sb.push_back(e);
        end
        for (int k = 0; k < 200 && edgeCnt < a + 2 * sp; k++) @(negedge clk);
        start = 1'b0;
        waitIdle(200);
        check("held_rBus", {14'd0, rBus}, 32'h1A610);

        // Abort by reset mid-operation
        issue(16'h8000, 1'b0);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_rBus", {14'd0, rBus}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        doneBefore = doneCnt;
        @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        check("abort_no_done", doneCnt - doneBefore, 0);
        check("abort_rBus_after", {14'd0, rBus}, 32'd0);
        check("abort_busy_after", {31'd0, busy}, 32'd0);

        // Mixed operands against the model
        issue(16'hFFFF, 1'b1);
        waitIdle(200);
        issue(16'h0100, 1'b1);
        waitIdle(200);
        for (int k = 0; k < 4; k++) begin
            issue(16'($urandom_range(0, 65535)), 1'b1);
            waitIdle(200);
        end

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
